// File: rtl/nios_core_pio_pkg.sv
// Shared register map for the NIOS_core PIO slaves (LED output and key input ports).
// Software header generation reads the same constants.
package nios_core_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/nios_core_blink_timer.sv
// Free-running half-period counter with a toggling phase flop.
// Exposes the next-state phase so the parent can register LED drive in the same edge.
module nios_core_blink_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic [PERIOD_W-1:0] period,
   output logic                phase,
   output logic                phase_next
);

   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_next;

   // A period load restarts the half-period and wins over a coincident wrap.
   always_comb begin
      cnt_next   = cnt + PERIOD_W'(1);
      phase_next = phase;
      if (load) begin
         cnt_next   = '0;
         phase_next = 1'b1;
      end else if (cnt == period) begin
         cnt_next   = '0;
         phase_next = ~phase;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else begin
         cnt   <= cnt_next;
         phase <= phase_next;
      end
   end

endmodule

// File: rtl/nios_core_led_pio.sv
// Avalon-MM LED output PIO: data register with atomic set/clear and per-bit blinking.
// Read data is registered with latency 1; LED drive is registered from next-state values.
module nios_core_led_pio
   import nios_core_pio_pkg::*;
#(
   parameter int                  WIDTH          = 8,
   parameter logic [WIDTH-1:0]    RESET_VALUE    = '0,
   parameter int                  PERIOD_W       = 24,
   parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(2_499_999)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0]    data, data_next;
   logic [WIDTH-1:0]    blink_en, blink_en_next;
   logic [PERIOD_W-1:0] period, period_next;
   logic                period_load;
   logic                phase, phase_next;
   logic                wr;
   logic [WIDTH-1:0]    wdata;
   logic [31:0]         read_mux;

   assign wr          = chipselect & ~write_n;
   assign wdata       = writedata[WIDTH-1:0];
   assign period_load = wr && (address == ADDR_PERIOD);

   nios_core_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (period_load),
      .period     (period),
      .phase      (phase),
      .phase_next (phase_next)
   );

   // Register write decode, including the read-modify-write set/clear aliases of DATA.
   always_comb begin
      data_next     = data;
      blink_en_next = blink_en;
      period_next   = period;
      if (wr) begin
         case (address)
            ADDR_DATA:     data_next     = wdata;
            ADDR_BLINK_EN: blink_en_next = wdata;
            ADDR_PERIOD:   period_next   = writedata[PERIOD_W-1:0];
            ADDR_OUTSET:   data_next     = data | wdata;
            ADDR_OUTCLEAR: data_next     = data & ~wdata;
            default:       ;
         endcase
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA:     read_mux = 32'(data);
         ADDR_BLINK_EN: read_mux = 32'(blink_en);
         ADDR_PERIOD:   read_mux = 32'(period);
         ADDR_STATUS:   read_mux[STATUS_PHASE_BIT] = phase;
         default:       ;
      endcase
   end

   // Blink-enabled bits are forced low during the off phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= RESET_VALUE;
         blink_en <= '0;
         period   <= DEFAULT_PERIOD;
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         data     <= data_next;
         blink_en <= blink_en_next;
         period   <= period_next;
         readdata <= read_mux;
         out_port <= data_next & ~(blink_en_next & ~{WIDTH{phase_next}});
      end
   end

endmodule
